// File: rtl/sched_pkg.sv
// Shared opcode constants and the per-slot decode used by the issue scheduler.
// Decode extracts register fields and the read/write usage of each operand.
package sched_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] opc;
    opc         = instr[6:0];
    d.rd        = instr[11:7];
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.uses_rs1  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) ||
                    (opc == OPC_JAL));
    d.uses_rs2  = (opc == OPC_OP) || (opc == OPC_STORE) ||
                  (opc == OPC_BRANCH);
    d.writes_rd = !((opc == OPC_STORE) || (opc == OPC_BRANCH)) &&
                  (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Busy-register scoreboard: set by issuing writers, cleared by writebacks.
// A set and a clear of the same register in one cycle leaves it busy.
module sched_scoreboard
  import sched_pkg::*;
#(
  parameter int WB_PORTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_set,
  input  logic [WB_PORTS-1:0]   i_wb_valid,
  input  logic [WB_PORTS*5-1:0] i_wb_rd,
  output logic [31:0]           o_busy,
  output logic [31:0]           o_clr
);

  logic [31:0] r_busy;
  logic [31:0] w_clr;

  // decode writeback strobes into a one-hot-per-port clear vector
  always_comb begin
    w_clr = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (i_wb_valid[k]) w_clr[i_wb_rd[5*k +: 5]] = 1'b1;
    end
    w_clr[0] = 1'b0;
  end

  // busy bits: clear first, then set so a same-cycle set wins; x0 stays 0
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | i_set) & 32'hFFFF_FFFE;
  end

  assign o_busy = r_busy;
  assign o_clr  = w_clr;

endmodule

// File: rtl/issue_scheduler.sv
// N-wide in-order issue scheduler: holds one bundle and issues the
// longest hazard-free prefix each cycle against a register scoreboard.
module issue_scheduler
  import sched_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ISSUE_W*32-1:0] in_instr,
  input  logic [ISSUE_W-1:0]    in_mask,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [ISSUE_W-1:0]    lane_en,
  output logic [ISSUE_W*32-1:0] lane_instr,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [WB_PORTS*5-1:0] wb_rd,
  output logic                  dep_stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [ISSUE_W*32-1:0] r_instr;
  logic [ISSUE_W-1:0]    r_pending;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [31:0]           w_busy;
  logic [31:0]           w_clr;
  logic [31:0]           w_set;
  logic [ISSUE_W-1:0]    w_lane_en;
  logic                  w_accept;
  logic                  w_dep_stall;

  sched_scoreboard #(
    .WB_PORTS (WB_PORTS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_set),
    .i_wb_valid (wb_valid),
    .i_wb_rd    (wb_rd),
    .o_busy     (w_busy),
    .o_clr      (w_clr)
  );

  // in-order prefix issue; the set vector doubles as the
  // record of destinations claimed by earlier slots this cycle
  always_comb begin
    dec_t               d;
    logic               ok;
    logic               haz;
    logic [ISSUE_W-1:0] en;
    logic [31:0]        set;
    d   = '0;
    haz = 1'b0;
    en  = '0;
    set = '0;
    ok  = out_ready & ~flush;
    for (int i = 0; i < ISSUE_W; i++) begin
      d   = decode(r_instr[32*i +: 32]);
      haz = 1'b0;
      if (d.uses_rs1 && d.rs1 != 5'd0) begin
        if (w_busy[d.rs1] && !w_clr[d.rs1]) haz = 1'b1;
        if (set[d.rs1])                     haz = 1'b1;
      end
      if (d.uses_rs2 && d.rs2 != 5'd0) begin
        if (w_busy[d.rs2] && !w_clr[d.rs2]) haz = 1'b1;
        if (set[d.rs2])                     haz = 1'b1;
      end
      if (d.writes_rd) begin
        if (w_busy[d.rd] && !w_clr[d.rd]) haz = 1'b1;
        if (set[d.rd])                    haz = 1'b1;
      end
      en[i] = ok & r_pending[i] & ~haz;
      if (en[i] && d.writes_rd) set[d.rd] = 1'b1;
      if (r_pending[i] && !en[i]) ok = 1'b0;
    end
    w_lane_en = en;
    w_set     = set;
  end

  assign in_ready    = (r_pending == '0);
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_dep_stall = (r_pending != '0) & out_ready &
                       (w_lane_en == '0) & ~flush;

  // bundle hold: flush drops everything, accept loads, issue retires slots
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_instr   <= '0;
    end else if (flush) begin
      r_pending <= '0;
    end else if (w_accept) begin
      r_instr   <= in_instr;
      r_pending <= in_mask;
    end else begin
      r_pending <= r_pending & ~w_lane_en;
    end
  end

  // saturating count of dependency-stall cycles
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_dep_stall && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign lane_en    = w_lane_en;
  assign lane_instr = r_instr;
  assign dep_stall  = w_dep_stall;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler (2-wide, 2 wb ports, 4-bit counter).
// Table vectors plus hand sequences; issued instructions checked via a queue.
module tb_issue_scheduler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_instr;
  logic [1:0]  in_mask;
  logic        out_ready;
  logic        flush;
  logic [1:0]  lane_en;
  logic [63:0] lane_instr;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        dep_stall;
  logic [3:0]  stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          lane;
    logic [31:0] instr;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  mask;
    logic [1:0]  en1;
    logic [1:0]  en2;
  } vec_t;
  vec_t tbl[10];

  issue_scheduler #(
    .ISSUE_W  (2),
    .WB_PORTS (2),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_mask    (in_mask),
    .out_ready  (out_ready),
    .flush      (flush),
    .lane_en    (lane_en),
    .lane_instr (lane_instr),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .dep_stall  (dep_stall),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_r(input logic [6:0] f7,
                                      input int rd, rs1, rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] f_add(input int rd, rs1, rs2);
    return f_r(7'h00, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] f_sub(input int rd, rs1, rs2);
    return f_r(7'h20, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] f_addi(input int rd, rs1, imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] f_lui(input int rd, imm);
    return {20'(imm), 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] f_sw(input int rs2, rs1, imm);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'(imm), 7'h23};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int lane, input logic [31:0] instr);
    exp_t e;
    e.lane  = lane;
    e.instr = instr;
    q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // settle, then pop one expectation per issuing lane
  task automatic look();
    exp_t e;
    #2;
    for (int l = 0; l < 2; l++) begin
      if (lane_en[l]) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: lane %0d issued %0h, none expected",
                   l, lane_instr[32*l +: 32]);
        end else begin
          e = q.pop_front();
          chk("sb_lane", 32'(l), 32'(e.lane));
          chk("sb_instr", lane_instr[32*l +: 32], e.instr);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    wb_valid  = '0;
    wb_rd     = '0;
    out_ready = 1'b1;
    in_instr  = '0;
    in_mask   = '0;
    next();
    next();
    rst = 1'b0;
    look();
    chk("sb_drain", 32'(q.size()), 32'd0);
  endtask

  task automatic offer(input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] m);
    in_instr = {i1, i0};
    in_mask  = m;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [1:0]  rem;
    logic [31:0] a;
    logic [31:0] b;

    tbl[0] = '{f_add(1,2,3),   f_add(4,5,6),     2'b11, 2'b11, 2'b00};
    tbl[1] = '{f_add(1,2,3),   f_sub(5,1,4),     2'b11, 2'b01, 2'b00};
    tbl[2] = '{f_addi(0,0,1),  f_addi(0,0,2),    2'b11, 2'b11, 2'b00};
    tbl[3] = '{f_add(1,2,3),   f_add(4,5,6),     2'b10, 2'b10, 2'b00};
    tbl[4] = '{f_addi(3,0,1),  f_addi(3,0,2),    2'b11, 2'b01, 2'b00};
    tbl[5] = '{f_add(8,1,2),   f_lui(9,64),      2'b11, 2'b11, 2'b00};
    tbl[6] = '{f_sw(1,2,5),    f_add(10,5,5),    2'b11, 2'b11, 2'b00};
    tbl[7] = '{f_add(3,1,2),   f_sw(3,4,0),      2'b11, 2'b01, 2'b00};
    tbl[8] = '{f_addi(7,0,1),  f_addi(9,3,7),    2'b11, 2'b11, 2'b00};
    tbl[9] = '{f_add(1,2,3),   f_add(4,1,6),     2'b01, 2'b01, 2'b00};

    do_reset();
    chk("rst_lane_en", 32'(lane_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dep_stall", 32'(dep_stall), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      offer(tbl[v].i0, tbl[v].i1, tbl[v].mask);
      chk("vec_ready0", 32'(in_ready), 32'd1);
      next();
      in_valid = 1'b0;
      for (int l = 0; l < 2; l++)
        if (tbl[v].en1[l]) push(l, l == 0 ? tbl[v].i0 : tbl[v].i1);
      look();
      chk("vec_en1", 32'(lane_en), 32'(tbl[v].en1));
      chk("vec_ready1", 32'(in_ready), 32'(tbl[v].mask == 2'b00));
      next();
      for (int l = 0; l < 2; l++)
        if (tbl[v].en2[l]) push(l, l == 0 ? tbl[v].i0 : tbl[v].i1);
      look();
      rem = tbl[v].mask & ~tbl[v].en1;
      chk("vec_en2", 32'(lane_en), 32'(tbl[v].en2));
      chk("vec_ready2", 32'(in_ready), 32'(rem == 2'b00));
      chk("vec_stall2", 32'(dep_stall),
          32'(rem != 2'b00 && tbl[v].en2 == 2'b00));
    end

    // intra-bundle RAW released by same-cycle writeback
    do_reset();
    a = f_add(1,2,3);
    b = f_sub(5,1,4);
    offer(a, b, 2'b11);
    next();
    in_valid = 1'b0;
    push(0, a);
    look();
    chk("raw_en1", 32'(lane_en), 32'd1);
    next();
    look();
    chk("raw_en2", 32'(lane_en), 32'd0);
    chk("raw_stall", 32'(dep_stall), 32'd1);
    next();
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd1};
    push(1, b);
    look();
    chk("raw_bypass", 32'(lane_en), 32'd2);
    chk("raw_nostall", 32'(dep_stall), 32'd0);
    next();
    wb_valid = '0;
    look();
    chk("raw_ready", 32'(in_ready), 32'd1);
    chk("raw_x1_free", 32'(dut.u_sb.o_busy[1]), 32'd0);
    chk("raw_x5_busy", 32'(dut.u_sb.o_busy[5]), 32'd1);

    // cross-bundle dependency on x7 with stall counting
    do_reset();
    a = f_addi(7,0,5);
    b = f_add(8,7,7);
    offer(a, 32'd0, 2'b01);
    next();
    in_valid = 1'b0;
    push(0, a);
    look();
    chk("xb_en1", 32'(lane_en), 32'd1);
    next();
    look();
    chk("xb_ready", 32'(in_ready), 32'd1);
    offer(b, 32'd0, 2'b01);
    next();
    in_valid = 1'b0;
    look();
    chk("xb_stall_en", 32'(lane_en), 32'd0);
    chk("xb_stall", 32'(dep_stall), 32'd1);
    chk("xb_cnt0", 32'(stall_cnt), 32'd0);
    next();
    look();
    chk("xb_stall_en2", 32'(lane_en), 32'd0);
    chk("xb_cnt1", 32'(stall_cnt), 32'd1);
    next();
    wb_valid = 2'b10;
    wb_rd    = {5'd7, 5'd0};
    push(0, b);
    look();
    chk("xb_bypass", 32'(lane_en), 32'd1);
    chk("xb_cnt2", 32'(stall_cnt), 32'd2);
    next();
    wb_valid = '0;
    look();
    chk("xb_cnt_hold", 32'(stall_cnt), 32'd2);

    // flush mid-stall, then a dropped offer during flush
    do_reset();
    a = f_add(1,2,3);
    b = f_sub(5,1,4);
    offer(a, b, 2'b11);
    next();
    in_valid = 1'b0;
    push(0, a);
    look();
    chk("fl_en1", 32'(lane_en), 32'd1);
    next();
    flush = 1'b1;
    offer(f_add(10,2,3), f_add(11,2,3), 2'b11);
    look();
    chk("fl_en_forced", 32'(lane_en), 32'd0);
    chk("fl_nostall", 32'(dep_stall), 32'd0);
    next();
    look();
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_en_idle", 32'(lane_en), 32'd0);
    chk("fl_x1_kept", 32'(dut.u_sb.o_busy[1]), 32'd1);
    next();
    flush    = 1'b0;
    in_valid = 1'b0;
    look();
    chk("fl_dropped_en", 32'(lane_en), 32'd0);
    chk("fl_dropped_rdy", 32'(in_ready), 32'd1);
    chk("fl_dropped_st", 32'(dep_stall), 32'd0);

    // same-cycle set and clear of x9, then reset over a held bundle
    do_reset();
    a = f_addi(9,0,1);
    b = f_addi(9,0,3);
    offer(a, 32'd0, 2'b01);
    next();
    in_valid = 1'b0;
    push(0, a);
    look();
    chk("sc_en1", 32'(lane_en), 32'd1);
    next();
    offer(b, 32'd0, 2'b01);
    next();
    in_valid = 1'b0;
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd9};
    push(0, b);
    look();
    chk("sc_waw_bypass", 32'(lane_en), 32'd1);
    next();
    wb_valid = '0;
    look();
    chk("sc_x9_busy", 32'(dut.u_sb.o_busy[9]), 32'd1);
    offer(f_add(1,9,9), 32'd0, 2'b01);
    next();
    in_valid = 1'b0;
    look();
    chk("sc_held", 32'(lane_en), 32'd0);
    chk("sc_stall", 32'(dep_stall), 32'd1);
    next();
    rst   = 1'b1;
    flush = 1'b1;
    look();
    next();
    rst   = 1'b0;
    flush = 1'b0;
    look();
    chk("sc_rst_en", 32'(lane_en), 32'd0);
    chk("sc_rst_ready", 32'(in_ready), 32'd1);
    chk("sc_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("sc_rst_busy", dut.u_sb.o_busy, 32'd0);

    // out_ready low holds state; then saturate the counter
    do_reset();
    out_ready = 1'b0;
    a = f_add(1,2,3);
    b = f_sub(5,1,4);
    offer(a, b, 2'b11);
    next();
    in_valid = 1'b0;
    look();
    chk("or_en0", 32'(lane_en), 32'd0);
    chk("or_nostall", 32'(dep_stall), 32'd0);
    next();
    look();
    chk("or_held", 32'(lane_en), 32'd0);
    chk("or_cnt", 32'(stall_cnt), 32'd0);
    out_ready = 1'b1;
    push(0, a);
    look();
    chk("or_release", 32'(lane_en), 32'd1);
    for (int c = 0; c < 20; c++) begin
      next();
      look();
    end
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    next();
    look();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    chk("sat_stall", 32'(dep_stall), 32'd1);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
